// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers, 32-cycle fixed latency.
// Define MDU_DIV_EN to compile in the DIV/DIVU datapath; otherwise divide requests are ignored.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_reg;
    logic [5:0]  cnt_reg;
    logic        neg_a_reg;
    logic        neg_b_reg;
    logic [31:0] opnd_reg;   // constant operand: multiplicand or divisor magnitude
    logic [31:0] acc_reg;    // product upper half / partial remainder
    logic [31:0] low_reg;    // multiplier shifting out / dividend shifting into quotient
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        busy_reg;
    logic        done_reg;

    logic        is_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        accept;
    logic [32:0] mul_sum;
    logic [63:0] product;
    logic [31:0] iter_acc;
    logic [31:0] iter_low;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

`ifdef MDU_DIV_EN
    logic        div_reg;
    logic [32:0] div_trial;
    logic [31:0] div_acc;
    logic [31:0] div_low;
`endif

    assign is_signed = ~op_i[0];
    assign mag_a     = (is_signed && rs_i[31]) ? -rs_i : rs_i;
    assign mag_b     = (is_signed && rt_i[31]) ? -rt_i : rt_i;

`ifdef MDU_DIV_EN
    assign accept = start_i;
`else
    assign accept = start_i && !op_i[1];
`endif

    always_comb begin
        mul_sum  = {1'b0, acc_reg} + (low_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        iter_acc = mul_sum[32:1];
        iter_low = {mul_sum[0], low_reg[31:1]};
        product  = {iter_acc, iter_low};
        if (neg_a_reg ^ neg_b_reg)
            product = -product;
        res_hi = product[63:32];
        res_lo = product[31:0];
`ifdef MDU_DIV_EN
        div_trial = {acc_reg, low_reg[31]} - {1'b0, opnd_reg};
        if (!div_trial[32]) begin
            div_acc = div_trial[31:0];
            div_low = {low_reg[30:0], 1'b1};
        end else begin
            div_acc = {acc_reg[30:0], low_reg[31]};
            div_low = {low_reg[30:0], 1'b0};
        end
        if (div_reg) begin
            iter_acc = div_acc;
            iter_low = div_low;
            // With a zero divisor every trial succeeds, so the remainder ends up as |rs|.
            res_hi = neg_a_reg ? -div_acc : div_acc;
            if (opnd_reg == 32'd0)
                res_lo = 32'hFFFF_FFFF;
            else
                res_lo = (neg_a_reg ^ neg_b_reg) ? -div_low : div_low;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 6'd0;
            neg_a_reg <= 1'b0;
            neg_b_reg <= 1'b0;
            opnd_reg  <= 32'd0;
            acc_reg   <= 32'd0;
            low_reg   <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef MDU_DIV_EN
            div_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= 6'd0;
                        neg_a_reg <= is_signed & rs_i[31];
                        neg_b_reg <= is_signed & rt_i[31];
                        acc_reg   <= 32'd0;
`ifdef MDU_DIV_EN
                        div_reg   <= op_i[1];
                        opnd_reg  <= op_i[1] ? mag_b : mag_a;
                        low_reg   <= op_i[1] ? mag_a : mag_b;
`else
                        opnd_reg  <= mag_a;
                        low_reg   <= mag_b;
`endif
                    end else if (!start_i) begin
                        if (mthi_i)
                            hi_reg <= wdata_i;
                        if (mtlo_i)
                            lo_reg <= wdata_i;
                    end
                end
                RUN: begin
                    acc_reg <= iter_acc;
                    low_reg <= iter_low;
                    cnt_reg <= cnt_reg + 6'd1;
                    if (cnt_reg == 6'd31) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        hi_reg    <= res_hi;
                        lo_reg    <= res_lo;
                    end
                end
            endcase
        end
    end

    assign busy_o = busy_reg;
    assign done_o = done_reg;
    assign hi_o   = hi_reg;
    assign lo_o   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised bench for mult_div_unit against a plain-arithmetic HI/LO reference model.
// Divide tests switch on MDU_DIV_EN; without it divide requests must be ignored.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic        mthi_i;
    logic        mtlo_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int tests_run;
    int tests_failed;

    mult_div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .rs_i    (rs_i),
        .rt_i    (rt_i),
        .mthi_i  (mthi_i),
        .mtlo_i  (mtlo_i),
        .wdata_i (wdata_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {HI, LO} expected from the architectural definition of each operation.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ref_model = 64'd0;
        case (op)
            2'b00: ref_model = sa * sb;
            2'b01: ref_model = ua * ub;
            2'b10: begin
                if (b == 32'd0) ref_model = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) ref_model = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    ref_model = {ur[31:0], uq[31:0]};
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Issues one operation at the current negedge and samples 33 negedges (after E0 .. after E32).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, output int busy_cycles, output int done_cnt,
                          output int done_at, output bit held,
                          output logic [31:0] hi_r, output logic [31:0] lo_r);
        logic [31:0] hi0, lo0;
        hi0 = hi_o;
        lo0 = lo_o;
        start_i = 1'b1;
        op_i    = op;
        rs_i    = a;
        rt_i    = b;
        busy_cycles = 0;
        done_cnt    = 0;
        done_at     = -1;
        held        = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start_i = 1'b0;
                mthi_i  = 1'b0;
                mtlo_i  = 1'b0;
                rs_i    = $urandom;
                rt_i    = $urandom;
            end
            if (busy_o) busy_cycles++;
            if (done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (busy_o && (hi_o !== hi0 || lo_o !== lo0)) held = 1'b0;
            if (inject && i == 5) begin
                start_i = 1'b1;
                op_i    = 2'($urandom);
                rs_i    = $urandom;
                rt_i    = $urandom;
                mthi_i  = 1'b1;
                mtlo_i  = 1'b1;
                wdata_i = 32'h1234_5678;
            end
            if (inject && i == 6) begin
                start_i = 1'b0;
                mthi_i  = 1'b0;
                mtlo_i  = 1'b0;
            end
        end
        hi_r = hi_o;
        lo_r = lo_o;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy_o, done_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/done=%b expected 00", {busy_o, done_o});
        end
        tests_run++;
        if ({hi_o, lo_o} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_hilo: got %h expected 0", {hi_o, lo_o});
        end
        rst = 1'b0;
    endtask

    // Fixed vectors, the first one issued on the first edge after reset release.
    task automatic test_mult_vectors();
        logic [1:0]  ops [2];
        logic [31:0] as  [2];
        logic [31:0] bs  [2];
        int bc, dc, da;
        bit held;
        logic [31:0] hr, lr;
        logic [63:0] exp_v [2];
        ops = '{2'b01, 2'b00};
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
        bs  = '{32'hFFFF_FFFF, 32'd7};
        exp_v = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB};
        for (int k = 0; k < 2; k++) begin
            run_op(ops[k], as[k], bs[k], 1'b0, bc, dc, da, held, hr, lr);
            $display("[TB] mult_vec op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d done=%0d@%0d",
                     ops[k], as[k], bs[k], hr, lr, bc, dc, da);
            tests_run++;
            if ({hr, lr} !== exp_v[k]) begin
                tests_failed++;
                $display("FAIL mult_vec%0d: got %h expected %h", k, {hr, lr}, exp_v[k]);
            end
            tests_run++;
            if (bc != 32 || dc != 1 || da != 32) begin
                tests_failed++;
                $display("FAIL mult_vec%0d_timing: busy=%0d done=%0d@%0d expected 32,1@32", k, bc, dc, da);
            end
        end
    endtask

    task automatic test_random_mult();
        int bc, dc, da;
        bit held;
        logic [31:0] a, b, hr, lr;
        logic [1:0] op;
        logic [63:0] exp_v;
        for (int k = 0; k < 10; k++) begin
            op = {1'b0, 1'(k % 2)};
            a = pick_operand();
            b = pick_operand();
            exp_v = ref_model(op, a, b);
            run_op(op, a, b, 1'b0, bc, dc, da, held, hr, lr);
            $display("[TB] rand_mult op=%0d a=%h b=%h -> hi=%h lo=%h", op, a, b, hr, lr);
            tests_run++;
            if ({hr, lr} !== exp_v || bc != 32 || dc != 1 || da != 32 || !held) begin
                tests_failed++;
                $display("FAIL rand_mult%0d: got %h busy=%0d done=%0d@%0d held=%0d expected %h,32,1@32,1",
                         k, {hr, lr}, bc, dc, da, held, exp_v);
            end
        end
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        int bc, dc, da;
        bit held;
        logic [31:0] a, b, hr, lr;
        logic [1:0] op;
        logic [63:0] exp_v;
        logic [1:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        ops = '{2'b10, 2'b11, 2'b10, 2'b10};
        as  = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FF00};
        bs  = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
        for (int k = 0; k < 14; k++) begin
            if (k < 4) begin
                op = ops[k]; a = as[k]; b = bs[k];
            end else begin
                op = {1'b1, 1'(k % 2)};
                a = pick_operand();
                b = ($urandom_range(0, 5) == 0) ? 32'd0 : pick_operand();
            end
            exp_v = ref_model(op, a, b);
            run_op(op, a, b, 1'b0, bc, dc, da, held, hr, lr);
            $display("[TB] div op=%0d a=%h b=%h -> hi=%h lo=%h", op, a, b, hr, lr);
            tests_run++;
            if ({hr, lr} !== exp_v || bc != 32 || dc != 1 || da != 32 || !held) begin
                tests_failed++;
                $display("FAIL div%0d: got %h busy=%0d done=%0d@%0d held=%0d expected %h,32,1@32,1",
                         k, {hr, lr}, bc, dc, da, held, exp_v);
            end
        end
    endtask
`else
    task automatic test_div_disabled();
        int bc, dc, da;
        bit held;
        logic [31:0] hr, lr, hi0, lo0;
        for (int k = 0; k < 2; k++) begin
            hi0 = hi_o;
            lo0 = lo_o;
            run_op({1'b1, 1'(k)}, $urandom, 32'd3, 1'b0, bc, dc, da, held, hr, lr);
            $display("[TB] div_disabled op=%0d -> busy=%0d done=%0d hi=%h lo=%h", {1'b1, 1'(k)}, bc, dc, hr, lr);
            tests_run++;
            if (bc != 0 || dc != 0 || hr !== hi0 || lr !== lo0) begin
                tests_failed++;
                $display("FAIL div_disabled%0d: busy=%0d done=%0d hilo=%h expected 0,0,%h",
                         k, bc, dc, {hr, lr}, {hi0, lo0});
            end
        end
    endtask
`endif

    task automatic test_move();
        int bc, dc, da;
        bit held;
        logic [31:0] hr, lr;
        mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi_i = 1'b0; mtlo_i = 1'b0;
        $display("[TB] move both -> hi=%h lo=%h", hi_o, lo_o);
        tests_run++;
        if (hi_o !== 32'hA5A5_A5A5 || lo_o !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL move_both: got %h expected a5a5a5a5a5a5a5a5", {hi_o, lo_o});
        end
        mthi_i = 1'b1; wdata_i = 32'h0BAD_F00D;
        @(negedge clk);
        mthi_i = 1'b0;
        tests_run++;
        if (hi_o !== 32'h0BAD_F00D || lo_o !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL move_hi: got %h expected 0badf00da5a5a5a5", {hi_o, lo_o});
        end
        mtlo_i = 1'b1; wdata_i = 32'hCAFE_0001;
        @(negedge clk);
        mtlo_i = 1'b0;
        tests_run++;
        if (hi_o !== 32'h0BAD_F00D || lo_o !== 32'hCAFE_0001) begin
            tests_failed++;
            $display("FAIL move_lo: got %h expected 0badf00dcafe0001", {hi_o, lo_o});
        end
        mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'h1111_1111;
        run_op(2'b01, 32'd2, 32'd3, 1'b0, bc, dc, da, held, hr, lr);
        $display("[TB] move+start -> hi=%h lo=%h held=%0d", hr, lr, held);
        tests_run++;
        if (!held || bc != 32 || hr !== 32'd0 || lr !== 32'd6) begin
            tests_failed++;
            $display("FAIL move_with_start: held=%0d busy=%0d hilo=%h expected 1,32,0000000000000006",
                     held, bc, {hr, lr});
        end
    endtask

    task automatic test_ignore_during_run();
        int bc, dc, da;
        bit held;
        logic [31:0] a, b, hr, lr;
        logic [63:0] exp_v;
        a = $urandom;
        b = $urandom;
        exp_v = ref_model(2'b00, a, b);
        run_op(2'b00, a, b, 1'b1, bc, dc, da, held, hr, lr);
        $display("[TB] ignore_in_run a=%h b=%h -> hi=%h lo=%h", a, b, hr, lr);
        tests_run++;
        if ({hr, lr} !== exp_v || bc != 32 || dc != 1 || da != 32 || !held) begin
            tests_failed++;
            $display("FAIL ignore_in_run: got %h busy=%0d done=%0d@%0d held=%0d expected %h,32,1@32,1",
                     {hr, lr}, bc, dc, da, held, exp_v);
        end
        // A late start_i must not have launched a second operation.
        @(negedge clk);
        tests_run++;
        if (busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_in_run_restart: busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_reset_mid_run();
        int bc, dc, da, done_seen;
        bit held;
        logic [31:0] hr, lr;
        mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        mthi_i = 1'b0; mtlo_i = 1'b0;
        start_i = 1'b1; op_i = 2'b00; rs_i = $urandom; rt_i = $urandom;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        $display("[TB] reset_mid_run -> busy=%b done=%b hi=%h lo=%h", busy_o, done_o, hi_o, lo_o);
        tests_run++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: busy=%b done=%b hilo=%h expected 0,0,0", busy_o, done_o, {hi_o, lo_o});
        end
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o || busy_o) done_seen++;
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: activity cycles=%0d expected 0", done_seen);
        end
        run_op(2'b01, 32'd2, 32'd3, 1'b0, bc, dc, da, held, hr, lr);
        tests_run++;
        if (hr !== 32'd0 || lr !== 32'd6 || dc != 1) begin
            tests_failed++;
            $display("FAIL reset_then_multu: hilo=%h done=%0d expected 0000000000000006,1", {hr, lr}, dc);
        end
    endtask

    task automatic test_back_to_back();
        int bc, dc, da;
        bit held;
        logic [31:0] a, b, hr, lr;
        logic [1:0] op;
        logic [63:0] exp_v;
        for (int k = 0; k < 3; k++) begin
            op = {1'b0, 1'(k % 2)};
            a = pick_operand();
            b = pick_operand();
            exp_v = ref_model(op, a, b);
            run_op(op, a, b, 1'b0, bc, dc, da, held, hr, lr);
            $display("[TB] b2b op=%0d a=%h b=%h -> hi=%h lo=%h done=%0d", op, a, b, hr, lr, dc);
            tests_run++;
            if ({hr, lr} !== exp_v || bc != 32 || dc != 1 || da != 32) begin
                tests_failed++;
                $display("FAIL b2b%0d: got %h busy=%0d done=%0d@%0d expected %h,32,1@32",
                         k, {hr, lr}, bc, dc, da, exp_v);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst     = 1'b1;
        start_i = 1'b0;
        op_i    = 2'b00;
        rs_i    = 32'd0;
        rt_i    = 32'd0;
        mthi_i  = 1'b0;
        mtlo_i  = 1'b0;
        wdata_i = 32'd0;
        test_reset();
        test_mult_vectors();
        test_random_mult();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_move();
        test_ignore_during_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  request a new operation; sampled at rising edge.
REQ-005 op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i.
REQ-006 rs_i  input  32  operand A (multiplicand / dividend), forwarded EX-stage value.
REQ-007 rt_i  input  32  operand B (multiplier / divisor), forwarded EX-stage value.
REQ-008 mthi_i  input  1  write wdata_i into HI.
REQ-009 mtlo_i  input  1  write wdata_i into LO.
REQ-010 wdata_i  input  32  data for MTHI/MTLO.
REQ-011 busy_o  output  1  operation in progress; the pipeline stall source.
REQ-012 done_o  output  1  one-cycle completion pulse.
REQ-013 hi_o  output  32  HI register (product upper half / remainder).
REQ-014 lo_o  output  32  LO register (product lower half / quotient).

Function
REQ-015 FSM states: IDLE, RUN; busy_o = (state == RUN), registered.
REQ-016 IDLE + start_i at edge E0: latch operand magnitudes and op, clear 6-bit counter, go to RUN.
REQ-017 RUN: one radix-2 iteration per cycle (shift-add multiply, restoring divide), counter +1 per edge.
REQ-018 Edge E32: apply sign fix-up, load HI/LO, go to IDLE, set done_o high for exactly the following cycle.
REQ-019 Latency: busy_o high for exactly 32 cycles (after E0 through E32); HI/LO visible the cycle after E32.
REQ-020 HI/LO hold their previous values throughout RUN; no partial results are visible.
REQ-021 MULT/MULTU: {HI,LO} = 64-bit product of signed/unsigned operands.
REQ-022 DIV: LO = quotient truncated toward zero; HI = remainder, sign follows dividend.
REQ-023 DIVU: unsigned quotient in LO, remainder in HI.
REQ-024 Divide by zero (DIV or DIVU): same 32-cycle latency; HI = rs_i, LO = 0xFFFFFFFF.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000; no trap.
REQ-026 start_i while RUN is ignored; the in-flight operation is unaffected.
REQ-027 mthi_i/mtlo_i in IDLE write HI/LO at the edge; both may assert together.
REQ-028 mthi_i/mtlo_i while RUN are ignored.
REQ-029 start_i together with mthi_i/mtlo_i in IDLE: start_i wins; the move is dropped.
REQ-030 Operands are captured at E0; later changes to rs_i/rt_i have no effect.

Reset
REQ-031 rst asserted: state = IDLE, counter = 0, hi_o = lo_o = 0x00000000, busy_o = 0, done_o = 0, immediately and asynchronously.
REQ-032 Reset during RUN aborts the operation; done_o is never pulsed for it.
REQ-033 First operation is accepted at the first rising edge after rst deasserts.

Configuration
REQ-034 Macro MDU_DIV_EN defined: DIV/DIVU datapath compiled in and behaves as REQ-022 to REQ-025.
REQ-035 MDU_DIV_EN undefined: no divider logic; start_i with op_i[1] = 1 is ignored (busy_o stays 0, done_o stays 0, HI/LO unchanged); multiply and MTHI/MTLO are unaffected.

Verification
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 32 busy cycles: HI = 0xFFFFFFFE, LO = 0x00000001; done_o pulses once.
REQ-037 MULT -3 x 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
REQ-038 DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 100 / 0 -> HI = 0x00000064, LO = 0xFFFFFFFF.
REQ-039 MULT started, rst pulsed on RUN cycle 10 -> busy_o = 0, HI = LO = 0, no done_o; a following MULTU 2 x 3 gives LO = 6, HI = 0.
REQ-040 During RUN, pulse start_i and mthi_i (wdata_i = 0x12345678) -> both ignored; the original result lands at E32.
REQ-041 IDLE, mthi_i and mtlo_i with wdata_i = 0xA5A5A5A5 -> HI = LO = 0xA5A5A5A5 the next cycle; with start_i also high -> move dropped, operation starts.
